ysyx_25040111_lsu: RTL and testbench

Load/store and writeback stage directly downstream of the execute unit.
- Accepts one executed instruction per handshake.
- Performs at most one memory access over a single-outstanding request/response bus, aligning store data and extracting/extending load data.
- Returns the GPR/CSR writeback, the commit PC and the `finish`/`frd` pair that releases the execute stage's load register lock.

---
 rtl/ysyx_25040111_lsu.sv | 221 ++++++++++++++++++++++
 tb/tb_ysyx_25040111_lsu.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25040111_lsu.sv
// Load/store + writeback stage. Accepts one executed instruction at a time,
// issues at most one memory access over a single-outstanding req/resp bus,
// and produces a one-cycle commit pulse carrying the GPR/CSR writeback.
module ysyx_25040111_lsu #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_men,
  input  logic        in_write,
  input  logic [1:0]  in_mask,
  input  logic        in_rsign,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  input  logic [4:0]  in_ard,
  input  logic [31:0] in_rd,
  input  logic        in_gen,
  input  logic [11:0] in_acsr,
  input  logic [31:0] in_csr,
  input  logic        in_sen,
  input  logic [31:0] in_pc,
  output logic        req_valid,
  input  logic        req_ready,
  output logic        req_write,
  output logic [31:0] req_addr,
  output logic [31:0] req_wdata,
  output logic [3:0]  req_wstrb,
  input  logic        resp_valid,
  input  logic [31:0] resp_rdata,
  input  logic        resp_err,
  output logic        wb_valid,
  output logic        wb_gen,
  output logic [4:0]  wb_ard,
  output logic [31:0] wb_rd,
  output logic        wb_sen,
  output logic [11:0] wb_acsr,
  output logic [31:0] wb_csr,
  output logic [31:0] wb_pc,
  output logic        finish,
  output logic [4:0]  frd,
  output logic        err_misalign,
  output logic        err_bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  logic [1:0]  state;
  logic [7:0]  cnt_q;
  logic        write_q, rsign_q, sen_q, gen_q, mis_q, bus_q;
  logic [1:0]  mask_q;
  logic [31:0] addr_q, wdata_q, res_q, csr_q, pc_q;
  logic [4:0]  ard_q;
  logic [11:0] acsr_q;

  logic        in_misaligned;
  logic [31:0] shifted;
  logic [31:0] load_data;
  logic [31:0] lane_wdata;
  logic [3:0]  lane_wstrb;

  // Alignment check on the incoming request, decided at acceptance time.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    in_misaligned = 1'b0;
    case (in_mask)
      2'b10:   in_misaligned = in_addr[0];
      2'b11:   in_misaligned = (in_addr[1:0] != 2'b00);
      default: in_misaligned = 1'b0;
    endcase
  end

  // Store lane replication and byte strobes from the latched access.
  always_comb begin
    lane_wdata = 32'd0;
    lane_wstrb = 4'b0000;
    case (mask_q)
      2'b01: begin
        lane_wdata = {4{wdata_q[7:0]}};
        lane_wstrb = 4'b0001 << addr_q[1:0];
      end
      2'b10: begin
        lane_wdata = {2{wdata_q[15:0]}};
        lane_wstrb = 4'b0011 << {addr_q[1], 1'b0};
      end
      2'b11: begin
        lane_wdata = wdata_q;
        lane_wstrb = 4'b1111;
      end
      default: begin
        lane_wdata = 32'd0;
        lane_wstrb = 4'b0000;
      end
    endcase
  end

  // Load extraction: shift the addressed lane down, then sign/zero extend.
  always_comb begin
    shifted   = resp_rdata >> {addr_q[1:0], 3'b000};
    load_data = shifted;
    case (mask_q)
      2'b01:   load_data = {{24{rsign_q & shifted[7]}}, shifted[7:0]};
      2'b10:   load_data = {{16{rsign_q & shifted[15]}}, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  // Transaction FSM, input latch and commit result registers.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (reset) begin
      state   <= S_IDLE;
      cnt_q   <= 8'd0;
      write_q <= 1'b0;
      rsign_q <= 1'b0;
      sen_q   <= 1'b0;
      gen_q   <= 1'b0;
      mis_q   <= 1'b0;
      bus_q   <= 1'b0;
      mask_q  <= 2'b00;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      res_q   <= 32'd0;
      csr_q   <= 32'd0;
      pc_q    <= 32'd0;
      ard_q   <= 5'd0;
      acsr_q  <= 12'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            write_q <= in_write;
            rsign_q <= in_rsign;
            sen_q   <= in_sen;
            mask_q  <= in_mask;
            addr_q  <= in_addr;
            wdata_q <= in_wdata;
            res_q   <= in_rd;
            csr_q   <= in_csr;
            pc_q    <= in_pc;
            ard_q   <= in_ard;
            acsr_q  <= in_acsr;
            cnt_q   <= 8'd0;
            bus_q   <= 1'b0;
            // A store never writes a GPR, even if gen was set upstream.
            gen_q   <= in_gen & ~(in_men & in_write);
            mis_q   <= 1'b0;
            if (!in_men) begin
              state <= S_DONE;
            end else if (in_misaligned) begin
              state <= S_DONE;
              gen_q <= 1'b0;
              mis_q <= 1'b1;
            end else begin
              state <= S_REQ;
            end
          end
        end
        S_REQ: begin
          // A response arriving here belongs to nobody and is dropped.
          if (req_ready) begin
            state <= S_WAIT;
            cnt_q <= 8'd0;
          end
        end
        S_WAIT: begin
          if (resp_valid) begin
            state <= S_DONE;
            if (resp_err) begin
              bus_q <= 1'b1;
              gen_q <= 1'b0;
            end else if (!write_q) begin
              res_q <= load_data;
            end
          end else if (cnt_q == CNT_LAST) begin
            state <= S_DONE;
            bus_q <= 1'b1;
            gen_q <= 1'b0;
          end else if (cnt_q != 8'hFF) begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  logic in_done;
  logic in_req;
  assign in_done = (state == S_DONE);
  assign in_req  = (state == S_REQ);

  assign in_ready     = (state == S_IDLE);
  assign req_valid    = in_req;
  assign req_write    = in_req & write_q;
  assign req_addr     = in_req ? {addr_q[31:2], 2'b00} : 32'd0;
  assign req_wdata    = in_req ? lane_wdata : 32'd0;
  assign req_wstrb    = in_req ? lane_wstrb : 4'b0000;

  assign wb_valid     = in_done;
  assign wb_gen       = in_done & gen_q;
  assign wb_ard       = in_done ? ard_q  : 5'd0;
  assign wb_rd        = in_done ? res_q  : 32'd0;
  assign wb_sen       = in_done & sen_q;
  assign wb_acsr      = in_done ? acsr_q : 12'd0;
  assign wb_csr       = in_done ? csr_q  : 32'd0;
  assign wb_pc        = in_done ? pc_q   : 32'd0;
  assign finish       = wb_valid;
  assign frd          = wb_ard;
  assign err_misalign = in_done & mis_q;
  assign err_bus      = in_done & bus_q;

endmodule

// File: tb/tb_ysyx_25040111_lsu.sv
// Directed bench for the load/store/writeback stage.
module tb_ysyx_25040111_lsu;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, in_men, in_write, in_rsign, in_gen, in_sen;
  logic [1:0]  in_mask;
  logic [31:0] in_addr, in_wdata, in_rd, in_csr, in_pc;
  logic [4:0]  in_ard;
  logic [11:0] in_acsr;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        wb_valid, wb_gen, wb_sen, finish, err_misalign, err_bus;
  logic [4:0]  wb_ard, frd;
  logic [31:0] wb_rd, wb_csr, wb_pc;
  logic [11:0] wb_acsr;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  ysyx_25040111_lsu dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_men(in_men), .in_write(in_write),
    .in_mask(in_mask), .in_rsign(in_rsign), .in_addr(in_addr), .in_wdata(in_wdata),
    .in_ard(in_ard), .in_rd(in_rd), .in_gen(in_gen), .in_acsr(in_acsr),
    .in_csr(in_csr), .in_sen(in_sen), .in_pc(in_pc),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .wb_valid(wb_valid), .wb_gen(wb_gen), .wb_ard(wb_ard), .wb_rd(wb_rd),
    .wb_sen(wb_sen), .wb_acsr(wb_acsr), .wb_csr(wb_csr), .wb_pc(wb_pc),
    .finish(finish), .frd(frd), .err_misalign(err_misalign), .err_bus(err_bus)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  // Present one instruction for a single cycle (stage assumed idle).
  task automatic accept(input logic men, input logic wr, input logic [1:0] mask,
                        input logic rsign, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [4:0] ard, input logic [31:0] rd, input logic gen,
                        input logic [11:0] acsr, input logic [31:0] csr, input logic sen,
                        input logic [31:0] pc);
    in_valid = 1'b1; in_men = men; in_write = wr; in_mask = mask; in_rsign = rsign;
    in_addr = addr; in_wdata = wdata; in_ard = ard; in_rd = rd; in_gen = gen;
    in_acsr = acsr; in_csr = csr; in_sen = sen; in_pc = pc;
    step();
    in_valid = 1'b0; in_men = 1'b0; in_write = 1'b0; in_addr = 32'd0; in_wdata = 32'd0;
  endtask

  int n;
  int wb_seen;

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_men = 1'b0; in_write = 1'b0; in_mask = 2'b00;
    in_rsign = 1'b0; in_addr = 32'd0; in_wdata = 32'd0; in_ard = 5'd0; in_rd = 32'd0;
    in_gen = 1'b0; in_acsr = 12'd0; in_csr = 32'd0; in_sen = 1'b0; in_pc = 32'd0;
    req_ready = 1'b0; resp_valid = 1'b0; resp_rdata = 32'd0; resp_err = 1'b0;
    @(negedge clock);
    step();

    // Reset state
    check("rst_in_ready", in_ready, 1);
    check("rst_req_valid", req_valid, 0);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_req_addr", req_addr, 0);
    check("rst_err", {err_misalign, err_bus, finish}, 0);
    reset = 1'b0;
    step();

    // ALU op: commit one cycle after acceptance
    accept(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 5'd5, 32'h1234, 1'b1, 12'h0, 32'h0, 1'b0, 32'h100);
    check("alu_wb_valid", wb_valid, 1);
    check("alu_wb_ard", wb_ard, 5);
    check("alu_wb_rd", wb_rd, 32'h1234);
    check("alu_wb_gen", wb_gen, 1);
    check("alu_finish", finish, 1);
    check("alu_frd", frd, 5);
    check("alu_wb_pc", wb_pc, 32'h100);
    check("alu_in_ready_done", in_ready, 0);
    check("alu_req_valid", req_valid, 0);
    step();
    check("alu_wb_valid_drop", wb_valid, 0);
    check("alu_in_ready_back", in_ready, 1);

    // Load byte signed, req_ready held off two cycles
    accept(1'b1, 1'b0, 2'b01, 1'b1, 32'h80000003, 32'h0, 5'd7, 32'h0, 1'b1, 12'h0, 32'h0, 1'b0, 32'h104);
    check("lb_req_valid", req_valid, 1);
    check("lb_req_addr", req_addr, 32'h80000000);
    check("lb_req_write", req_write, 0);
    step();
    check("lb_req_hold1", req_valid, 1);
    step();
    check("lb_req_hold2", req_valid, 1);
    check("lb_req_addr_stable", req_addr, 32'h80000000);
    // Response coincident with the handshake must be ignored
    req_ready = 1'b1; resp_valid = 1'b1; resp_rdata = 32'h00000000;
    step();
    req_ready = 1'b0; resp_valid = 1'b0;
    check("lb_req_drop", req_valid, 0);
    check("lb_early_resp_ignored", wb_valid, 0);
    resp_valid = 1'b1; resp_rdata = 32'h80FFFFFF;
    wb_seen = 0;
    step();
    resp_valid = 1'b0;
    check("lb_wb_valid", wb_valid, 1);
    check("lb_wb_rd", wb_rd, 32'hFFFFFF80);
    check("lb_wb_gen", wb_gen, 1);
    check("lb_errs", {err_misalign, err_bus}, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      if (wb_valid) wb_seen++;
    end
    check("lb_wb_once", wb_seen, 0);

    // Store half at addr 2
    accept(1'b1, 1'b1, 2'b10, 1'b0, 32'h00000002, 32'h0000ABCD, 5'd3, 32'h0, 1'b1, 12'h305, 32'hDEAD, 1'b1, 32'h108);
    check("sh_req_wdata", req_wdata, 32'hABCDABCD);
    check("sh_req_wstrb", req_wstrb, 4'b1100);
    check("sh_req_write", req_write, 1);
    check("sh_req_addr", req_addr, 32'h0);
    req_ready = 1'b1;
    step();
    req_ready = 1'b0; resp_valid = 1'b1;
    step();
    resp_valid = 1'b0;
    check("sh_wb_valid", wb_valid, 1);
    check("sh_wb_gen", wb_gen, 0);
    check("sh_wb_sen", wb_sen, 1);
    check("sh_wb_acsr", wb_acsr, 12'h305);
    check("sh_wb_csr", wb_csr, 32'hDEAD);
    step();

    // Store byte at addr 1
    accept(1'b1, 1'b1, 2'b01, 1'b0, 32'h00000401, 32'h0000005A, 5'd0, 32'h0, 1'b0, 12'h0, 32'h0, 1'b0, 32'h10C);
    check("sb_req_wdata", req_wdata, 32'h5A5A5A5A);
    check("sb_req_wstrb", req_wstrb, 4'b0010);
    check("sb_req_addr", req_addr, 32'h400);
    req_ready = 1'b1;
    step();
    req_ready = 1'b0; resp_valid = 1'b1;
    step();
    resp_valid = 1'b0;
    check("sb_wb_valid", wb_valid, 1);
    step();

    // Load half unsigned from upper lane
    accept(1'b1, 1'b0, 2'b10, 1'b0, 32'h00000012, 32'h0, 5'd9, 32'h0, 1'b1, 12'h0, 32'h0, 1'b0, 32'h110);
    req_ready = 1'b1;
    step();
    req_ready = 1'b0; resp_valid = 1'b1; resp_rdata = 32'h87651234;
    step();
    resp_valid = 1'b0;
    check("lhu_wb_rd", wb_rd, 32'h00008765);
    check("lhu_wb_ard", wb_ard, 9);
    step();

    // Misaligned word load: no bus activity
    accept(1'b1, 1'b0, 2'b11, 1'b0, 32'h00000006, 32'h0, 5'd4, 32'h0, 1'b1, 12'h0, 32'h0, 1'b0, 32'h114);
    check("mis_req_valid", req_valid, 0);
    check("mis_wb_valid", wb_valid, 1);
    check("mis_err_misalign", err_misalign, 1);
    check("mis_wb_gen", wb_gen, 0);
    check("mis_err_bus", err_bus, 0);
    step();
    check("mis_pulse_end", err_misalign, 0);

    // Load with no response: timeout after 255 WAIT cycles
    accept(1'b1, 1'b0, 2'b11, 1'b0, 32'h00000010, 32'h0, 5'd6, 32'h0, 1'b1, 12'h0, 32'h0, 1'b0, 32'h118);
    req_ready = 1'b1;
    step();
    req_ready = 1'b0;
    n = 0;
    while (!wb_valid && n < 400) begin
      step();
      n++;
    end
    check("to_cycles", n, 255);
    check("to_err_bus", err_bus, 1);
    check("to_wb_gen", wb_gen, 0);
    step();

    // Response error
    accept(1'b1, 1'b0, 2'b11, 1'b0, 32'h00000020, 32'h0, 5'd6, 32'h0, 1'b1, 12'h0, 32'h0, 1'b0, 32'h11C);
    req_ready = 1'b1;
    step();
    req_ready = 1'b0; resp_valid = 1'b1; resp_err = 1'b1; resp_rdata = 32'h55555555;
    step();
    resp_valid = 1'b0; resp_err = 1'b0;
    check("re_wb_valid", wb_valid, 1);
    check("re_err_bus", err_bus, 1);
    check("re_wb_gen", wb_gen, 0);
    step();

    // Reset in WAIT, then a stale response
    accept(1'b1, 1'b0, 2'b11, 1'b0, 32'h00000030, 32'h0, 5'd8, 32'h0, 1'b1, 12'h0, 32'h0, 1'b0, 32'h120);
    req_ready = 1'b1;
    step();
    req_ready = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rw_req_valid", req_valid, 0);
    check("rw_in_ready", in_ready, 1);
    check("rw_wb_valid", wb_valid, 0);
    resp_valid = 1'b1; resp_rdata = 32'h12345678;
    wb_seen = 0;
    step();
    resp_valid = 1'b0;
    if (wb_valid) wb_seen++;
    for (int i = 0; i < 3; i++) begin
      step();
      if (wb_valid) wb_seen++;
    end
    check("rw_no_wb", wb_seen, 0);
    check("rw_in_ready_after", in_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
